// File: rtl/coproc_sequencer.sv
// Control sequencer for the matrix coprocessor: accepts decoded instructions,
// runs memory read/write and ALU start/done transactions, and reports status.
module coproc_sequencer #(
   parameter int ALU_TIMEOUT = 1024,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        dec_opcode,
   input  logic [ADDR_W-1:0] dec_adrs,
   input  logic [DATA_W-1:0] dec_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              alu_start,
   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] alu_scalar,
   input  logic              alu_done,
   input  logic              alu_overflow,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              instr_done,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_overflow
);

   typedef enum logic [2:0] {
      ST_INIT, ST_IDLE, ST_MEM_RD, ST_MEM_WAIT,
      ST_MEM_WR, ST_ALU_START, ST_ALU_WAIT, ST_DONE
   } state_t;

   localparam int               CNT_W    = $clog2(ALU_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

   state_t              r_state;
   state_t              w_next;
   logic                w_accept;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [2:0]          r_alu_op;
   logic [DATA_W-1:0]   r_scalar;
   logic [DATA_W-1:0]   r_result;
   logic                r_result_valid;
   logic                r_err_timeout;
   logic                r_err_overflow;

   assign w_accept = (r_state == ST_IDLE) && instr_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_INIT;
      else        r_state <= w_next;
   end

   // NOTE: w_next gets its default first so no path through the case infers a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_INIT:      w_next = ST_IDLE;
         ST_IDLE: begin
            if (instr_valid) begin
               if (dec_opcode[3]) begin
                  w_next = ST_DONE;
               end else begin
                  case (dec_opcode[2:0])
                     3'd0:    w_next = ST_DONE;
                     3'd1:    w_next = ST_MEM_RD;
                     3'd2:    w_next = ST_MEM_WR;
                     default: w_next = ST_ALU_START;
                  endcase
               end
            end
         end
         ST_MEM_RD:    w_next = ST_MEM_WAIT;
         ST_MEM_WAIT:  w_next = ST_DONE;
         ST_MEM_WR:    w_next = ST_DONE;
         ST_ALU_START: w_next = ST_ALU_WAIT;
         ST_ALU_WAIT:  if (alu_done || (r_cnt == CNT_LAST)) w_next = ST_DONE;
         ST_DONE:      w_next = ST_IDLE;
         default:      w_next = ST_INIT;
      endcase
   end

   // Address, write data and ALU op only load for the instruction that uses
   // them, so they hold their last values across unrelated instructions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt          <= '0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_alu_op       <= '0;
         r_scalar       <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_err_timeout  <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         r_result_valid <= (r_state == ST_MEM_WAIT);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_err_timeout  <= 1'b0;
                  r_err_overflow <= 1'b0;
                  if (dec_opcode[3]) begin
                     r_scalar <= dec_data;
                  end else begin
                     case (dec_opcode[2:0])
                        3'd0: ;
                        3'd1: r_addr <= dec_adrs;
                        3'd2: begin
                           r_addr  <= dec_adrs;
                           r_wdata <= dec_data;
                        end
                        default: r_alu_op <= dec_opcode[2:0];
                     endcase
                  end
               end
            end
            ST_MEM_WAIT:  r_result <= mem_rdata;
            ST_ALU_START: r_cnt <= '0;
            ST_ALU_WAIT: begin
               // A done coincident with the last counted cycle takes priority.
               if (alu_done)                r_err_overflow <= alu_overflow;
               else if (r_cnt == CNT_LAST)  r_err_timeout  <= 1'b1;
               else                         r_cnt          <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign instr_ready  = (r_state == ST_IDLE);
   assign busy         = (r_state != ST_IDLE) && (r_state != ST_INIT);
   assign mem_re       = (r_state == ST_MEM_RD);
   assign mem_we       = (r_state == ST_MEM_WR);
   assign alu_start    = (r_state == ST_ALU_START);
   assign instr_done   = (r_state == ST_DONE);
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign alu_op       = r_alu_op;
   assign alu_scalar   = r_scalar;
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign err_timeout  = r_err_timeout;
   assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_coproc_sequencer.sv
// Self-checking bench for coproc_sequencer with a memory model, a scripted ALU
// model and a read-result scoreboard.
module tb_coproc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  dec_opcode;
   logic [7:0]  dec_adrs;
   logic [15:0] dec_data;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [15:0] mem_rdata;
   logic        alu_start;
   logic [2:0]  alu_op;
   logic [15:0] alu_scalar;
   logic        alu_done;
   logic        alu_overflow;
   logic [15:0] result;
   logic        result_valid;
   logic        instr_done;
   logic        busy;
   logic        err_timeout;
   logic        err_overflow;

   int n_cmp = 0;
   int n_err = 0;

   coproc_sequencer #(.ALU_TIMEOUT(8), .DATA_W(16), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .dec_opcode(dec_opcode), .dec_adrs(dec_adrs), .dec_data(dec_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata),
      .alu_start(alu_start), .alu_op(alu_op), .alu_scalar(alu_scalar),
      .alu_done(alu_done), .alu_overflow(alu_overflow),
      .result(result), .result_valid(result_valid), .instr_done(instr_done),
      .busy(busy), .err_timeout(err_timeout), .err_overflow(err_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: write on mem_we, read data one cycle after mem_re.
   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   // ALU model: pulses done alu_delay cycles after the start cycle (0 = never).
   int   alu_delay = 0;
   logic alu_ovf_cfg = 1'b0;
   int   alu_cd = 0;
   always @(negedge clk) begin
      alu_done     = 1'b0;
      alu_overflow = 1'b0;
      if (alu_start) begin
         alu_cd = alu_delay;
      end else if (alu_cd > 0) begin
         alu_cd--;
         if (alu_cd == 0) begin
            alu_done     = 1'b1;
            alu_overflow = alu_ovf_cfg;
         end
      end
   end

   // Strobe monitor and read-result scoreboard.
   logic [15:0] sb [$];
   int          we_cnt = 0, re_cnt = 0, st_cnt = 0, n_done = 0, n_overlap = 0;
   logic [7:0]  cap_waddr, cap_raddr;
   logic [15:0] cap_wdata;
   logic [2:0]  cap_op;
   always @(negedge clk) begin
      if (rst_n) begin
         if ($countones({mem_we, mem_re, alu_start}) > 1) n_overlap++;
         if (mem_we)     begin we_cnt++; cap_waddr = mem_addr; cap_wdata = mem_wdata; end
         if (mem_re)     begin re_cnt++; cap_raddr = mem_addr; end
         if (alu_start)  begin st_cnt++; cap_op = alu_op; end
         if (instr_done) n_done++;
         if (result_valid) begin
            logic [15:0] exp_r;
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected: result_valid with result %h, none expected", result);
            end else begin
               exp_r = sb.pop_front();
               if (result !== exp_r || instr_done !== 1'b1) begin
                  n_err++;
                  $display("FAIL sb_result: result %h instr_done %b, required %h and 1",
                           result, instr_done, exp_r);
               end
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [7:0] adrs, input logic [15:0] data);
      int guard = 0;
      @(negedge clk);
      while (instr_ready !== 1'b1 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 64) begin
         n_cmp++; n_err++;
         $display("FAIL issue_ready: instr_ready %b, required 1", instr_ready);
      end
      instr_valid = 1'b1;
      dec_opcode  = op;
      dec_adrs    = adrs;
      dec_data    = data;
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (instr_done !== 1'b1 && lat < 64);
      if (instr_done !== 1'b1) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: instr_done %b after %0d cycles, required 1", instr_done, lat);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      instr_valid = 1'b0; dec_opcode = '0; dec_adrs = '0; dec_data = '0;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({instr_ready, busy, mem_we, mem_re, alu_start, result_valid, instr_done,
           err_timeout, err_overflow, mem_addr, mem_wdata, alu_op, alu_scalar, result} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: ready %b busy %b we %b re %b start %b rv %b done %b, required all 0",
                  instr_ready, busy, mem_we, mem_re, alu_start, result_valid, instr_done);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (instr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL init_ready: instr_ready %b in first cycle, required 0", instr_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (instr_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_ready: ready %b busy %b, required 1 and 0", instr_ready, busy);
      end
   endtask

   task automatic test_write_read();
      int lat;
      issue(4'h2, 8'h13, 16'hBEEF);
      wait_done(lat);
      n_cmp++;
      if (lat != 2 || we_cnt != 1 || cap_waddr !== 8'h13 || cap_wdata !== 16'hBEEF) begin
         n_err++;
         $display("FAIL write: lat %0d we %0d addr %h data %h, required 2 1 13 beef",
                  lat, we_cnt, cap_waddr, cap_wdata);
      end
      sb.push_back(16'hBEEF);
      issue(4'h1, 8'h13, 16'h0000);
      wait_done(lat);
      n_cmp++;
      if (lat != 3 || re_cnt != 1 || cap_raddr !== 8'h13) begin
         n_err++;
         $display("FAIL read: lat %0d re %0d addr %h, required 3 1 13", lat, re_cnt, cap_raddr);
      end
      issue(4'h2, 8'h7A, 16'h1234);
      wait_done(lat);
      sb.push_back(16'h1234);
      issue(4'h1, 8'h7A, 16'hFFFF);
      wait_done(lat);
      sb.push_back(16'hBEEF);
      issue(4'h1, 8'h13, 16'h0000);
      wait_done(lat);
      #1;
      n_cmp++;
      if (sb.size() != 0 || result !== 16'hBEEF || mem_addr !== 8'h13 || mem_wdata !== 16'h1234) begin
         n_err++;
         $display("FAIL read_hold: pending %0d result %h addr %h wdata %h, required 0 beef 13 1234",
                  sb.size(), result, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_alu_overflow();
      int lat;
      issue(4'h8, 8'h00, 16'h0042);
      wait_done(lat);
      n_cmp++;
      if (lat != 1 || alu_scalar !== 16'h0042) begin
         n_err++;
         $display("FAIL load_scalar: lat %0d scalar %h, required 1 0042", lat, alu_scalar);
      end
      alu_delay = 4; alu_ovf_cfg = 1'b1;
      issue(4'h5, 8'h00, 16'h0000);
      wait_done(lat);
      n_cmp++;
      if (lat != 6 || st_cnt != 1 || cap_op !== 3'd5 || err_overflow !== 1'b1 || err_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL alu_ovf: lat %0d starts %0d op %0d ovf %b tmo %b, required 6 1 5 1 0",
                  lat, st_cnt, cap_op, err_overflow, err_timeout);
      end
      issue(4'h0, 8'h00, 16'h0000);
      n_cmp++;
      if (err_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_clear: err_overflow %b after accept, required 0", err_overflow);
      end
      wait_done(lat);
   endtask

   task automatic test_timeout();
      int lat, snap;
      alu_delay = 12; alu_ovf_cfg = 1'b1;
      issue(4'h3, 8'h00, 16'h0000);
      wait_done(lat);
      n_cmp++;
      if (lat != 10 || err_timeout !== 1'b1 || err_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL timeout: lat %0d tmo %b ovf %b, required 10 1 0", lat, err_timeout, err_overflow);
      end
      #1 snap = n_done;
      repeat (4) @(negedge clk);
      #1;
      n_cmp++;
      if (n_done != snap || err_timeout !== 1'b1 || err_overflow !== 1'b0 || instr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL late_done: extra dones %0d tmo %b ovf %b ready %b, required 0 1 0 1",
                  n_done - snap, err_timeout, err_overflow, instr_ready);
      end
      issue(4'h0, 8'h00, 16'h0000);
      n_cmp++;
      if (err_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_clear: err_timeout %b after accept, required 0", err_timeout);
      end
      wait_done(lat);
      alu_delay = 8; alu_ovf_cfg = 1'b1;
      issue(4'h7, 8'h00, 16'h0000);
      wait_done(lat);
      n_cmp++;
      if (lat != 10 || err_timeout !== 1'b0 || err_overflow !== 1'b1 || cap_op !== 3'd7) begin
         n_err++;
         $display("FAIL done_wins: lat %0d tmo %b ovf %b op %0d, required 10 0 1 7",
                  lat, err_timeout, err_overflow, cap_op);
      end
   endtask

   task automatic test_back_to_back();
      bit exp_pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      int we_snap = we_cnt;
      @(negedge clk);
      instr_valid = 1'b1; dec_opcode = 4'h0; dec_adrs = 8'h00; dec_data = 16'h0000;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         n_cmp++;
         if (instr_done !== exp_pat[i]) begin
            n_err++;
            $display("FAIL b2b_cycle%0d: instr_done %b, required %b", i, instr_done, exp_pat[i]);
         end
         if (i == 0) begin dec_opcode = 4'h2; dec_adrs = 8'hEE; dec_data = 16'hDEAD; end
         if (i == 1) dec_opcode = 4'h0;
         if (i == 4) instr_valid = 1'b0;
      end
      n_cmp++;
      if (we_cnt != we_snap || mem_addr !== 8'h13) begin
         n_err++;
         $display("FAIL b2b_ignore: writes %0d addr %h, required 0 13", we_cnt - we_snap, mem_addr);
      end
   endtask

   task automatic test_reset_mid();
      int lat, snap;
      alu_delay = 0;
      issue(4'h4, 8'h00, 16'h0000);
      repeat (2) @(negedge clk);
      #1 snap = n_done;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, instr_ready, alu_start, mem_we, mem_re, err_timeout, err_overflow} !== '0 ||
          {result, alu_scalar, mem_addr, alu_op} !== '0) begin
         n_err++;
         $display("FAIL mid_reset: busy %b ready %b start %b result %h scalar %h addr %h, required all 0",
                  busy, instr_ready, alu_start, result, alu_scalar, mem_addr);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (n_done != snap || instr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_done: extra dones %0d ready %b, required 0 0", n_done - snap, instr_ready);
      end
      issue(4'h0, 8'h00, 16'h0000);
      wait_done(lat);
      n_cmp++;
      if (lat != 1) begin
         n_err++;
         $display("FAIL resume_nop: latency %0d, required 1", lat);
      end
      issue(4'h2, 8'h21, 16'h5A5A);
      wait_done(lat);
      sb.push_back(16'h5A5A);
      issue(4'h1, 8'h21, 16'h0000);
      wait_done(lat);
      n_cmp++;
      if (lat != 3) begin
         n_err++;
         $display("FAIL resume_read: latency %0d, required 3", lat);
      end
   endtask

   task automatic test_strobes();
      @(negedge clk);
      #1;
      n_cmp++;
      if (n_overlap != 0 || sb.size() != 0) begin
         n_err++;
         $display("FAIL strobes: overlaps %0d pending reads %0d, required 0 0", n_overlap, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_alu_overflow();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_strobes();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/coproc_sequencer.md
Name: coproc_sequencer

Overview:
- Control FSM for the matrix coprocessor.
- Accepts one 32-bit instruction at a time over a valid/ready handshake. The decoder converts that instruction combinationally into opcode/adrs/data fields, and this block latches those fields on acceptance.
- Sequences matrix-memory reads and writes and ALU start/done transactions, then reports completion and status.
- Sits between the host instruction bus and the memory/ALU datapath.

Parameters:
- ALU_TIMEOUT, 1024: max cycles in ALU_WAIT before aborting; legal range ≥2.
- DATA_W, 16: data/result width; matches decoder data field.
- ADDR_W, 8: memory address width; matches decoder adrs field.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  host has an instruction on the bus
- instr_ready  out  1  sequencer can accept
- dec_opcode  in  4  decoder opcode
- dec_adrs  in  ADDR_W  decoder element address
- dec_data  in  DATA_W  decoder immediate data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_re
- alu_start  out  1  one-cycle ALU launch pulse
- alu_op  out  3  ALU operation code
- alu_scalar  out  DATA_W  scalar operand register
- alu_done  in  1  ALU completion pulse
- alu_overflow  in  1  overflow flag, qualified by alu_done
- result  out  DATA_W  last READ data
- result_valid  out  1  one-cycle pulse when result updates
- instr_done  out  1  one-cycle pulse at end of every instruction
- busy  out  1  instruction in flight
- err_timeout  out  1  ALU timeout flag
- err_overflow  out  1  ALU overflow flag

Behaviour:
- States: INIT, IDLE, MEM_RD, MEM_WAIT, MEM_WR, ALU_START, ALU_WAIT, DONE.
- Reset (async, rst_n low): state=INIT; all outputs and registers are 0; instr_ready=0.
- INIT → IDLE unconditionally on the first edge with rst_n high.
- Outputs are Moore-decoded from registered state/registers. No combinational input→output paths.
- IDLE: instr_ready=1, busy=0. On instr_valid=1, latch opcode/adrs/data, clear err_timeout and err_overflow, and branch on the latched opcode:
  - opcode 0 NOP → DONE
  - opcode 1 READ → MEM_RD
  - opcode 2 WRITE → MEM_WR
  - opcodes 3–7 ALU ops → ALU_START; alu_op=opcode[2:0]
  - opcode[3]=1 LOAD_SCALAR: alu_scalar←dec_data on the accept edge, → DONE
- In every state other than IDLE: instr_ready=0, busy=1.
- MEM_RD: mem_re=1, mem_addr=latched adrs for 1 cycle → MEM_WAIT.
- MEM_WAIT: result←mem_rdata on exit edge; result_valid=1 during the following DONE cycle → DONE.
- MEM_WR: mem_we=1, mem_addr=adrs, mem_wdata=data for 1 cycle → DONE.
- ALU_START: alu_start=1 for exactly 1 cycle → ALU_WAIT; timeout counter←0.
- ALU_WAIT:
  - alu_done is sampled only in this state.
  - On alu_done: err_overflow←alu_overflow → DONE.
  - Otherwise counter increments each cycle. When counter reaches ALU_TIMEOUT−1 with no done: err_timeout←1 → DONE.
  - alu_done in the same cycle as timeout expiry: done wins, no timeout flagged.
- DONE: instr_done=1 for 1 cycle → IDLE.
- mem_we, mem_re and alu_start are never asserted simultaneously, and each is only asserted in its own state.
- mem_addr, mem_wdata and alu_op hold their last values between instructions.
- Latency from accept edge to instr_done high:
  - NOP/LOAD_SCALAR: 1 cycle
  - WRITE: 2 cycles
  - READ: 3 cycles
  - ALU: 2 + wait cycles
- Back-to-back issue: the next accept is possible in the cycle after DONE.
- Instruction inputs and instr_valid are ignored while not in IDLE. The host must hold instr_valid until it sees instr_ready.
- Error flags are sticky until the next accepted instruction; result and alu_scalar persist until overwritten.
- Reset mid-instruction: immediate return to INIT, all strobes deassert asynchronously, no done pulse, flags cleared.
- Stale alu_done arriving after a timeout abort: ignored, since the FSM is not in ALU_WAIT.

Test Plan:
- Release reset → instr_ready=0 in the first cycle, 1 from the second edge on. All outputs were 0 during reset.
- WRITE adrs=0x13, data=0xBEEF, then READ adrs=0x13 with memory model returning 0xBEEF → mem_we pulse with correct addr/wdata. READ gives mem_re pulse, result=0xBEEF with result_valid coincident with instr_done, READ latency 3.
- LOAD_SCALAR data=0x0042, then ALU op 5; model asserts alu_done+alu_overflow 4 cycles after start → alu_scalar=0x0042, single alu_start with alu_op=5, err_overflow=1, instr_done 1 cycle after done. Flag cleared on next accept.
- ALU op 3 with alu_done never asserted, ALU_TIMEOUT=8 → err_timeout=1 after 8 wait cycles. A late alu_done is ignored; the next NOP clears the flag.
- instr_valid held continuously with 3 queued NOPs → one accept every 2 cycles. Instruction changes while busy are ignored.
- rst_n pulsed low during ALU_WAIT → immediate strobe/flag clear, state INIT, no instr_done pulse, normal operation resumes.
